dmem_responder: RTL and testbench

//  Data-memory responder at the memory end of the pipeline's MEM-stage load/store port.

---
 rtl/dmem_responder.sv | 240 ++++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dmem_responder
//   Data-memory responder sitting at the memory end of the MEM-stage load/store
//   port. Each legal request is latched, held for WAIT_CYCLES wait states while
//   the pipeline is stalled, then completed with a one-cycle resp_valid pulse.
//   Byte/half/word stores write only their byte lanes; loads are lane-steered
//   and sign- or zero-extended. Misaligned or malformed requests are rejected
//   with a misalign_err pulse and perform no access.
//
// Ports
//   clk           in   1   rising-edge clock
//   rst           in   1   asynchronous active-low reset
//   MemR          in   1   load request (held while mem_stall=1)
//   MemWr         in   1   store request (held while mem_stall=1)
//   MemWrBits     in   2   store size: 00 word, 01 half, 10 byte, 11 reserved
//   MemRBits      in   3   load type: 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu
//   addr          in  32   byte address (wraps modulo DEPTH_WORDS*4)
//   wdata         in  32   store data, low bits used for half/byte
//   rdata         out 32   extended load result, valid with resp_valid
//   resp_valid    out  1   one-cycle pulse: transaction complete
//   mem_stall     out  1   freeze pipeline stages at and before MEM
//   misalign_err  out  1   one-cycle pulse: request rejected
// -----------------------------------------------------------------------------
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemR,
   input  logic        MemWr,
   input  logic [1:0]  MemWrBits,
   input  logic [2:0]  MemRBits,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        resp_valid,
   output logic        mem_stall,
   output logic        misalign_err
);

   localparam int         IDX_W     = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
   localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   // Load lane selection and extension; ltype uses the MemRBits encoding.
   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [2:0]  ltype,
                                               input logic [1:0]  off);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{off, 3'b000} +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (ltype)
         3'b000:  load_extend = word;
         3'b001:  load_extend = {{16{h[15]}}, h};
         3'b010:  load_extend = {16'h0000, h};
         3'b011:  load_extend = {{24{b[7]}}, b};
         3'b100:  load_extend = {24'h000000, b};
         default: load_extend = 32'h0000_0000;
      endcase
   endfunction

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [31:0]         rdata_q, rdata_d;
   logic                resp_valid_q, resp_valid_d;
   logic                misalign_err_q, misalign_err_d;

   // Latched request (datapath only, no reset needed)
   logic [IDX_W+1:0]    addr_q, addr_d;
   logic [2:0]          op_q, op_d;
   logic                store_q, store_d;
   logic [31:0]         wdata_q, wdata_d;

   logic [31:0]         mem_array [DEPTH_WORDS];

   logic                req, bad, legal, illegal;
   logic                acc_fire, acc_store, mem_we;
   logic [IDX_W+1:0]    acc_addr;
   logic [IDX_W-1:0]    acc_idx;
   logic [2:0]          acc_op;
   logic [31:0]         acc_wdata, rd_word;
   logic [3:0]          lane_be;
   logic [31:0]         lane_wd;

   logic                unused_addr_hi;
   assign unused_addr_hi = ^addr[31:IDX_W+2];

   // ---- request decode (IDLE cycle) ----
   always_comb begin
      req = MemR | MemWr;
      bad = 1'b0;
      if (MemR && MemWr) begin
         bad = 1'b1;
      end else if (MemWr) begin
         case (MemWrBits)
            2'b00:   bad = (addr[1:0] != 2'b00);
            2'b01:   bad = addr[0];
            2'b10:   bad = 1'b0;
            default: bad = 1'b1;
         endcase
      end else if (MemR) begin
         case (MemRBits)
            3'b000:         bad = (addr[1:0] != 2'b00);
            3'b001, 3'b010: bad = addr[0];
            3'b011, 3'b100: bad = 1'b0;
            default:        bad = 1'b1;
         endcase
      end
      legal   = req & ~bad;
      illegal = req & bad;
   end

   // ---- memory access stage ----
   // With zero wait states the access happens on the accept edge straight from
   // the ports; otherwise it happens on the last WAIT edge from the latched copy.
   always_comb begin
      acc_fire  = (state_q == S_WAIT) && (cnt_q == 4'd1);
      acc_addr  = addr_q;
      acc_op    = op_q;
      acc_store = store_q;
      acc_wdata = wdata_q;
      if (ZERO_WAIT && (state_q == S_IDLE)) begin
         acc_fire  = legal;
         acc_addr  = addr[IDX_W+1:0];
         acc_op    = MemWr ? {1'b0, MemWrBits} : MemRBits;
         acc_store = MemWr;
         acc_wdata = wdata;
      end
      acc_idx = acc_addr[IDX_W+1:2];
      rd_word = mem_array[acc_idx];
      mem_we  = acc_fire & acc_store;

      case (acc_op[1:0])
         2'b01: begin
            lane_be = acc_addr[1] ? 4'b1100 : 4'b0011;
            lane_wd = {2{acc_wdata[15:0]}};
         end
         2'b10: begin
            lane_be = 4'b0001 << acc_addr[1:0];
            lane_wd = {4{acc_wdata[7:0]}};
         end
         default: begin
            lane_be = 4'b1111;
            lane_wd = acc_wdata;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (lane_be[i]) mem_array[acc_idx][8*i +: 8] <= lane_wd[8*i +: 8];
         end
      end
   end

   // ---- control next-state ----
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      rdata_d        = rdata_q;
      resp_valid_d   = 1'b0;
      misalign_err_d = 1'b0;
      addr_d         = addr_q;
      op_d           = op_q;
      store_d        = store_q;
      wdata_d        = wdata_q;

      case (state_q)
         S_IDLE: begin
            if (illegal) begin
               misalign_err_d = 1'b1;
               resp_valid_d   = 1'b1;
               rdata_d        = 32'h0000_0000;
            end else if (legal) begin
               addr_d  = addr[IDX_W+1:0];
               op_d    = MemWr ? {1'b0, MemWrBits} : MemRBits;
               store_d = MemWr;
               wdata_d = wdata;
               cnt_d   = WAIT_INIT;
               if (ZERO_WAIT) begin
                  state_d      = S_RESP;
                  resp_valid_d = 1'b1;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d      = S_RESP;
               resp_valid_d = 1'b1;
            end
         end
         default: begin
            // RESP: the pipeline advances on this edge, so a held request is
            // not seen again until the next IDLE cycle.
            state_d = S_IDLE;
         end
      endcase

      if (acc_fire && !acc_store) rdata_d = load_extend(rd_word, acc_op, acc_addr[1:0]);
   end

   // ---- registered control and outputs ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= S_IDLE;
         cnt_q          <= 4'd0;
         rdata_q        <= 32'h0000_0000;
         resp_valid_q   <= 1'b0;
         misalign_err_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         rdata_q        <= rdata_d;
         resp_valid_q   <= resp_valid_d;
         misalign_err_q <= misalign_err_d;
      end
   end

   always_ff @(posedge clk) begin
      addr_q  <= addr_d;
      op_q    <= op_d;
      store_q <= store_d;
      wdata_q <= wdata_d;
   end

   assign mem_stall    = ((state_q == S_IDLE) && legal) || (state_q == S_WAIT);
   assign rdata        = rdata_q;
   assign resp_valid   = resp_valid_q;
   assign misalign_err = misalign_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
// Scoreboard bench for dmem_responder: unit 0 uses two wait states and the
// default depth, unit 1 uses zero wait states and a 16-word depth so address
// aliasing is easy to reach.
module tb_dmem_responder;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic        chk;
      logic [7:0]  id;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic        r_a, w_a, r_z, w_z;
   logic [1:0]  wb_a, wb_z;
   logic [2:0]  rb_a, rb_z;
   logic [31:0] addr_a, wdata_a, addr_z, wdata_z;
   logic [31:0] rdata_a, rdata_z;
   logic        rv_a, rv_z, stall_a, stall_z, err_a, err_z;

   exp_t q_a[$];
   exp_t q_z[$];
   int   checks = 0;
   int   errs   = 0;

   dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .MemR(r_a), .MemWr(w_a), .MemWrBits(wb_a), .MemRBits(rb_a),
      .addr(addr_a), .wdata(wdata_a), .rdata(rdata_a), .resp_valid(rv_a),
      .mem_stall(stall_a), .misalign_err(err_a));

   dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .MemR(r_z), .MemWr(w_z), .MemWrBits(wb_z), .MemRBits(rb_z),
      .addr(addr_z), .wdata(wdata_z), .rdata(rdata_z), .resp_valid(rv_z),
      .mem_stall(stall_z), .misalign_err(err_z));

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h required %h", nm, got, exp);
      end
   endtask

   task automatic mon_unit(input int u, input logic rv, input logic er, input logic [31:0] rd);
      exp_t e;
      if (rv) begin
         checks++;
         if ((u == 0 && q_a.size() == 0) || (u == 1 && q_z.size() == 0)) begin
            errs++;
            $display("FAIL unexpected_resp u%0d: got resp_valid=1 required no response", u);
         end else begin
            e = (u == 0) ? q_a.pop_front() : q_z.pop_front();
            if (er !== e.err) begin
               errs++;
               $display("FAIL misalign_err u%0d id%0d: got %b required %b", u, e.id, er, e.err);
            end
            if (e.chk) begin
               checks++;
               if (rd !== e.rdata) begin
                  errs++;
                  $display("FAIL rdata u%0d id%0d: got %h required %h", u, e.id, rd, e.rdata);
               end
            end
         end
      end else if (er) begin
         checks++;
         errs++;
         $display("FAIL err_without_valid u%0d: got misalign_err=1 required 0", u);
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (rst) begin
            mon_unit(0, rv_a, err_a, rdata_a);
            mon_unit(1, rv_z, err_z, rdata_z);
         end
      end
   endtask

   task automatic idle_inputs();
      r_a = 0; w_a = 0; wb_a = 0; rb_a = 0; addr_a = 0; wdata_a = 0;
      r_z = 0; w_z = 0; wb_z = 0; rb_z = 0; addr_z = 0; wdata_z = 0;
   endtask

   // Called at posedge+1: presents the request, holds it while stalled, and
   // returns at posedge+1 of the cycle after the stall drops.
   task automatic issue(input int u, input logic r, input logic w, input logic [1:0] wb,
                        input logic [2:0] rb, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] er, input logic ee, input logic chk, input int id);
      exp_t e;
      int   n, es;
      bit   done;
      logic rv;
      e.rdata = er; e.err = ee; e.chk = chk; e.id = 8'(id);
      if (u == 0) begin
         r_a = r; w_a = w; wb_a = wb; rb_a = rb; addr_a = a; wdata_a = d;
         q_a.push_back(e);
      end else begin
         r_z = r; w_z = w; wb_z = wb; rb_z = rb; addr_z = a; wdata_z = d;
         q_z.push_back(e);
      end
      es = ee ? 0 : ((u == 0) ? 3 : 1);
      n = 0; done = 0; rv = 0;
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge clk);
         if ((u == 0) ? stall_a : stall_z) n++;
         else begin
            done = 1;
            rv = (u == 0) ? rv_a : rv_z;
         end
      end
      checks++;
      if (!done) begin
         errs++;
         $display("FAIL stall_timeout u%0d id%0d: got stall still high required release", u, id);
      end else if (n != es) begin
         errs++;
         $display("FAIL stall_cycles u%0d id%0d: got %0d required %0d", u, id, n, es);
      end
      if (!ee) begin
         checks++;
         if (rv !== 1'b1) begin
            errs++;
            $display("FAIL resp_latency u%0d id%0d: got resp_valid=%b required 1", u, id, rv);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic ld(input int u, input logic [2:0] rb, input logic [31:0] a,
                     input logic [31:0] exp, input int id);
      issue(u, 1, 0, 2'b00, rb, a, 32'h0, exp, 0, 1, id);
   endtask

   task automatic st(input int u, input logic [1:0] wb, input logic [31:0] a,
                     input logic [31:0] d, input int id);
      issue(u, 0, 1, wb, 3'b000, a, d, 32'h0, 0, 0, id);
   endtask

   task automatic bad(input int u, input logic r, input logic w, input logic [1:0] wb,
                      input logic [2:0] rb, input logic [31:0] a, input int id);
      issue(u, r, w, wb, rb, a, 32'h0000_FFFF, 32'h0, 1, 1, id);
   endtask

   initial begin
      rst = 0;
      idle_inputs();
      fork
         monitor();
      join_none

      repeat (2) @(posedge clk);
      #1;
      check("reset_rdata_a", rdata_a, 32'h0);
      check("reset_rv_a", {31'h0, rv_a}, 32'h0);
      check("reset_err_a", {31'h0, err_a}, 32'h0);
      check("reset_stall_a", {31'h0, stall_a}, 32'h0);
      check("reset_rdata_z", rdata_z, 32'h0);
      @(negedge clk);
      rst = 1;
      @(posedge clk);
      #1;

      // Two wait states
      st(0, 2'b00, 32'h10, 32'h8000_00F1, 1);
      ld(0, 3'b000, 32'h10, 32'h8000_00F1, 2);
      st(0, 2'b10, 32'h13, 32'h0000_00AB, 3);
      ld(0, 3'b011, 32'h13, 32'hFFFF_FFAB, 4);
      ld(0, 3'b100, 32'h13, 32'h0000_00AB, 5);
      ld(0, 3'b000, 32'h10, 32'hAB00_00F1, 6);
      ld(0, 3'b011, 32'h10, 32'hFFFF_FFF1, 7);
      st(0, 2'b01, 32'h12, 32'h0000_8001, 8);
      ld(0, 3'b001, 32'h12, 32'hFFFF_8001, 9);
      ld(0, 3'b010, 32'h12, 32'h0000_8001, 10);
      ld(0, 3'b000, 32'h10, 32'h8001_00F1, 11);
      ld(0, 3'b010, 32'h10, 32'h0000_00F1, 12);
      bad(0, 1, 0, 2'b00, 3'b000, 32'h11, 13);
      bad(0, 0, 1, 2'b01, 3'b000, 32'h13, 14);
      bad(0, 1, 1, 2'b00, 3'b000, 32'h10, 15);
      bad(0, 1, 0, 2'b00, 3'b111, 32'h10, 16);
      bad(0, 0, 1, 2'b11, 3'b000, 32'h10, 17);
      ld(0, 3'b000, 32'h10, 32'h8001_00F1, 18);
      ld(0, 3'b000, 32'h1010, 32'h8001_00F1, 19);
      st(0, 2'b00, 32'h20, 32'hCAFE_0000, 20);

      // Store aborted by reset in its second wait state
      r_a = 0; w_a = 1; wb_a = 2'b00; rb_a = 3'b000; addr_a = 32'h20; wdata_a = 32'h0000_1234;
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      idle_inputs();
      #1;
      check("abort_rdata", rdata_a, 32'h0);
      check("abort_rv", {31'h0, rv_a}, 32'h0);
      check("abort_err", {31'h0, err_a}, 32'h0);
      check("abort_stall", {31'h0, stall_a}, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1;
      @(posedge clk);
      #1;
      ld(0, 3'b000, 32'h20, 32'hCAFE_0000, 21);
      idle_inputs();

      // Zero wait states, back-to-back, 16-word depth
      st(1, 2'b00, 32'h00, 32'h1122_3344, 31);
      ld(1, 3'b000, 32'h40, 32'h1122_3344, 32);
      ld(1, 3'b000, 32'h00, 32'h1122_3344, 33);
      st(1, 2'b10, 32'h41, 32'h0000_005A, 34);
      ld(1, 3'b000, 32'h00, 32'h1122_5A44, 35);
      ld(1, 3'b010, 32'h02, 32'h0000_1122, 36);
      ld(1, 3'b100, 32'h41, 32'h0000_005A, 37);
      ld(1, 3'b001, 32'h42, 32'h0000_1122, 38);
      bad(1, 1, 0, 2'b00, 3'b000, 32'h43, 39);
      ld(1, 3'b000, 32'h00, 32'h1122_5A44, 40);
      idle_inputs();

      repeat (5) @(posedge clk);
      #1;
      check("pending_a", 32'(q_a.size()), 32'h0);
      check("pending_z", 32'(q_z.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
      $finish;
   end

endmodule
